// File: rtl/spi_note_transmitter_if.sv
// Note-event valid/ready port for spi_note_transmitter.
// master = event producer, slave = transmitter.
interface spi_note_transmitter_if;
    logic       ev_valid;
    logic       ev_ready;
    logic       ev_note_on;
    logic [7:0] ev_voice;
    logic [6:0] ev_note;
    logic [6:0] ev_velocity;

    modport master (
        output ev_valid, ev_note_on, ev_voice, ev_note, ev_velocity,
        input  ev_ready
    );

    modport slave (
        input  ev_valid, ev_note_on, ev_voice, ev_note, ev_velocity,
        output ev_ready
    );
endinterface

// File: rtl/spi_note_transmitter.sv
// SPI mode-0 master that serialises queued note events into
// 0x90/voice/note/vel (note-on) or 0x80/voice (note-off) byte streams.
module spi_note_transmitter #(
    parameter int CLK_DIV    = 4,
    parameter int GAP_CYCLES = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    spi_note_transmitter_if.slave         ev,
    output logic                          SPI_sclk,
    output logic                          SPI_mosi,
    output logic                          SPI_cs_n,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          msg_sent
);

    localparam int AW      = $clog2(FIFO_DEPTH);
    localparam int CNT_MAX = (CLK_DIV > GAP_CYCLES) ? CLK_DIV : GAP_CYCLES;
    localparam int CW      = $clog2(CNT_MAX) + 1;
    localparam logic [CW-1:0] DIV_LAST = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] GAP_LAST = CW'(GAP_CYCLES - 1);

    typedef enum logic [2:0] {IDLE, LOAD, LOW, HIGH, GAP} state_t;

    state_t state, state_n;

    logic [22:0]   mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    logic          full, empty, push, pop;

    logic          msg_on;
    logic [7:0]    msg_voice;
    logic [6:0]    msg_note, msg_vel;
    logic [1:0]    byte_idx;
    logic [7:0]    shreg, cur_byte;
    logic [2:0]    bit_cnt;
    logic [CW-1:0] cnt;
    logic          low_done, gap_done, last_byte;

    logic sclk_n, mosi_n, cs_n_n, busy_n, msg_n;

    assign full        = (count == (AW+1)'(FIFO_DEPTH));
    assign empty       = (count == '0);
    assign ev.ev_ready = !full && !reset;
    assign push        = ev.ev_valid && ev.ev_ready;
    assign pop         = (state == IDLE) && !empty;
    assign fifo_count  = count;

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= {ev.ev_note_on, ev.ev_voice, ev.ev_note, ev.ev_velocity};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_comb begin
        unique case (byte_idx)
            2'd0: cur_byte = msg_on ? 8'h90 : 8'h80;
            2'd1: cur_byte = msg_voice;
            2'd2: cur_byte = {1'b0, msg_note};
            2'd3: cur_byte = {1'b0, msg_vel};
        endcase
    end

    assign low_done  = (cnt == DIV_LAST);
    assign gap_done  = (cnt == GAP_LAST);
    assign last_byte = (byte_idx == (msg_on ? 2'd3 : 2'd1));

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_n;
    end

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE: if (!empty) state_n = LOAD;
            LOAD: state_n = LOW;
            LOW:  if (low_done) state_n = HIGH;
            HIGH: if (low_done) state_n = (bit_cnt == 3'd0) ? GAP : LOW;
            GAP:  if (gap_done) state_n = last_byte ? IDLE : LOAD;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt       <= '0;
            byte_idx  <= '0;
            bit_cnt   <= '0;
            shreg     <= '0;
            msg_on    <= 1'b0;
            msg_voice <= '0;
            msg_note  <= '0;
            msg_vel   <= '0;
        end else begin
            cnt <= (state_n == state) ? cnt + 1'b1 : '0;
            if (pop) begin
                {msg_on, msg_voice, msg_note, msg_vel} <= mem[rd_ptr];
                byte_idx <= '0;
            end
            if (state == LOAD) begin
                shreg   <= cur_byte;
                bit_cnt <= 3'd7;
            end
            if (state == HIGH && low_done && bit_cnt != 3'd0) begin
                shreg   <= {shreg[6:0], 1'b0};
                bit_cnt <= bit_cnt - 1'b1;
            end
            if (state == GAP && gap_done && !last_byte)
                byte_idx <= byte_idx + 1'b1;
        end
    end

    always_comb begin
        sclk_n = 1'b0;
        mosi_n = 1'b0;
        cs_n_n = 1'b1;
        msg_n  = 1'b0;
        busy_n = !empty || (state != IDLE);
        unique case (state)
            LOAD: begin
                cs_n_n = 1'b0;
                mosi_n = cur_byte[7];
            end
            LOW: begin
                cs_n_n = 1'b0;
                mosi_n = shreg[7];
            end
            HIGH: begin
                cs_n_n = 1'b0;
                sclk_n = 1'b1;
                mosi_n = shreg[7];
            end
            GAP:  msg_n = gap_done && last_byte;
            default: ;
        endcase
    end

    // Registered pins: every SPI edge lags its state by exactly one cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            SPI_sclk <= 1'b0;
            SPI_mosi <= 1'b0;
            SPI_cs_n <= 1'b1;
            busy     <= 1'b0;
            msg_sent <= 1'b0;
        end else begin
            SPI_sclk <= sclk_n;
            SPI_mosi <= mosi_n;
            SPI_cs_n <= cs_n_n;
            busy     <= busy_n;
            msg_sent <= msg_n;
        end
    end

endmodule

// File: tb/tb_spi_note_transmitter.sv
// Self-checking bench: default DUT plus a CLK_DIV=1/GAP_CYCLES=1 DUT,
// SPI bytes rebuilt on SCLK rises and scored against expected queues.
module tb_spi_note_transmitter;

    typedef struct packed {
        logic        on;
        logic [7:0]  voice;
        logic [6:0]  note;
        logic [6:0]  vel;
        logic [2:0]  nb;
        logic [31:0] bytes;
    } vec_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    spi_note_transmitter_if if0();
    spi_note_transmitter_if if1();

    logic [1:0] sclk, mosi, cs_n, busy, msg;
    logic [2:0] cnt0, cnt1;

    spi_note_transmitter dut0 (
        .clk(clk), .reset(reset), .ev(if0.slave),
        .SPI_sclk(sclk[0]), .SPI_mosi(mosi[0]), .SPI_cs_n(cs_n[0]),
        .busy(busy[0]), .fifo_count(cnt0), .msg_sent(msg[0])
    );

    spi_note_transmitter #(.CLK_DIV(1), .GAP_CYCLES(1)) dut1 (
        .clk(clk), .reset(reset), .ev(if1.slave),
        .SPI_sclk(sclk[1]), .SPI_mosi(mosi[1]), .SPI_cs_n(cs_n[1]),
        .busy(busy[1]), .fifo_count(cnt1), .msg_sent(msg[1])
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [1:0] p_sclk = 2'b00, p_cs = 2'b11, p_mosi = 2'b00;
    int bits[2]    = '{0, 0};
    int rises[2]   = '{0, 0};
    int glitch[2]  = '{0, 0};
    int hi_len[2]  = '{0, 0};
    int hi_max[2]  = '{0, 0};
    int msg_cnt[2] = '{0, 0};
    logic [7:0] sh[2];
    logic [7:0] rx0[$], rx1[$];
    int mc0[$], mc1[$];

    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (reset) begin
                bits[d] <= 0;
            end else begin
                if (!cs_n[d] && p_cs[d]) begin
                    bits[d] <= 0;
                end else if (sclk[d] && !p_sclk[d]) begin
                    bits[d]  <= bits[d] + 1;
                    sh[d]    <= {sh[d][6:0], mosi[d]};
                    rises[d] <= rises[d] + 1;
                end
                if (sclk[d] && p_sclk[d] && mosi[d] != p_mosi[d])
                    glitch[d] <= glitch[d] + 1;
                if (sclk[d])
                    hi_len[d] <= p_sclk[d] ? hi_len[d] + 1 : 1;
                if (!sclk[d] && p_sclk[d] && hi_len[d] > hi_max[d])
                    hi_max[d] <= hi_len[d];
                if (cs_n[d] && !p_cs[d] && bits[d] == 8) begin
                    if (d == 0) rx0.push_back(sh[d]);
                    else        rx1.push_back(sh[d]);
                end
                if (msg[d]) begin
                    msg_cnt[d] <= msg_cnt[d] + 1;
                    if (d == 0) mc0.push_back(cyc);
                    else        mc1.push_back(cyc);
                end
            end
            p_sclk[d] <= sclk[d];
            p_cs[d]   <= cs_n[d];
            p_mosi[d] <= mosi[d];
        end
    end

    int n_cmp = 0;
    int n_fail = 0;
    int rd0 = 0, rd1 = 0;
    logic [7:0] exq0[$], exq1[$];

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)",
                     name, act, act, exp, exp);
        end
    endtask

    function automatic vec_t mk(input logic on, input logic [7:0] voice,
                                input logic [6:0] note, input logic [6:0] vel);
        vec_t v;
        v.on    = on;
        v.voice = voice;
        v.note  = note;
        v.vel   = vel;
        v.nb    = on ? 3'd4 : 3'd2;
        v.bytes = on ? {8'h90, voice, 1'b0, note, 1'b0, vel}
                     : {8'h80, voice, 16'h0000};
        return v;
    endfunction

    function automatic logic rdy(input int d);
        return (d == 0) ? if0.ev_ready : if1.ev_ready;
    endfunction

    task automatic drive(input int d, input vec_t v, input logic val);
        if (d == 0) begin
            if0.ev_valid = val;      if0.ev_note_on = v.on;
            if0.ev_voice = v.voice;  if0.ev_note = v.note;
            if0.ev_velocity = v.vel;
        end else begin
            if1.ev_valid = val;      if1.ev_note_on = v.on;
            if1.ev_voice = v.voice;  if1.ev_note = v.note;
            if1.ev_velocity = v.vel;
        end
    endtask

    task automatic push_exp(input int d, input vec_t v);
        for (int j = 0; j < int'(v.nb); j++) begin
            if (d == 0) exq0.push_back(v.bytes[31-8*j -: 8]);
            else        exq1.push_back(v.bytes[31-8*j -: 8]);
        end
    endtask

    task automatic send(input int d, input vec_t v, output int acc);
        int i = 0;
        drive(d, v, 1'b1);
        while (!rdy(d) && i < 3000) begin
            @(negedge clk);
            i++;
        end
        chk("send_ready", int'(rdy(d)), 1);
        acc = cyc + 1;
        push_exp(d, v);
        @(negedge clk);
        drive(d, v, 1'b0);
    endtask

    task automatic wait_msgs(input int d, input int target, input int budget);
        int i = 0;
        while (msg_cnt[d] < target && i < budget) begin
            @(negedge clk);
            i++;
        end
        chk("msg_wait", msg_cnt[d], target);
    endtask

    task automatic drain(input int d, input string tag);
        int act;
        logic [7:0] e;
        if (d == 0) begin
            while (exq0.size() > 0) begin
                e = exq0.pop_front();
                act = (rd0 < rx0.size()) ? int'(rx0[rd0]) : -1;
                chk({tag, "_byte"}, act, int'(e));
                rd0++;
            end
            chk({tag, "_extra_rx"}, rx0.size() - rd0, 0);
            rd0 = rx0.size();
        end else begin
            while (exq1.size() > 0) begin
                e = exq1.pop_front();
                act = (rd1 < rx1.size()) ? int'(rx1[rd1]) : -1;
                chk({tag, "_byte"}, act, int'(e));
                rd1++;
            end
            chk({tag, "_extra_rx"}, rx1.size() - rd1, 0);
            rd1 = rx1.size();
        end
    endtask

    task automatic run_vec(input int d, input vec_t v, input int bt, input string tag);
        int r, m, acc, lat;
        r = rises[d];
        m = msg_cnt[d];
        send(d, v, acc);
        wait_msgs(d, m + 1, 20 * bt);
        repeat (2) @(negedge clk);
        lat = -1;
        if (d == 0 && mc0.size() > m) lat = mc0[m] - acc;
        if (d == 1 && mc1.size() > m) lat = mc1[m] - acc;
        chk({tag, "_latency"}, lat, 1 + int'(v.nb) * bt);
        chk({tag, "_rises"}, rises[d] - r, int'(v.nb) * 8);
        chk({tag, "_busy_idle"}, int'(busy[d]), 0);
        chk({tag, "_msg_count"}, msg_cnt[d] - m, 1);
        drain(d, tag);
    endtask

    vec_t tbl[5];
    vec_t fev[5];

    initial begin
        int k, t, m, r, acc, act;
        vec_t v;

        tbl[0] = '{on: 1'b1, voice: 8'h03, note: 7'd60,  vel: 7'd100, nb: 3'd4, bytes: 32'h90033C64};
        tbl[1] = '{on: 1'b0, voice: 8'h07, note: 7'd60,  vel: 7'd100, nb: 3'd2, bytes: 32'h80070000};
        tbl[2] = '{on: 1'b1, voice: 8'hFF, note: 7'd127, vel: 7'd127, nb: 3'd4, bytes: 32'h90FF7F7F};
        tbl[3] = '{on: 1'b0, voice: 8'h00, note: 7'd0,   vel: 7'd0,   nb: 3'd2, bytes: 32'h80000000};
        tbl[4] = '{on: 1'b1, voice: 8'h80, note: 7'd0,   vel: 7'd1,   nb: 3'd4, bytes: 32'h90800001};

        fev[0] = mk(1'b1, 8'h11, 7'd10, 7'd20);
        fev[1] = mk(1'b0, 8'h22, 7'd30, 7'd40);
        fev[2] = mk(1'b1, 8'h33, 7'd50, 7'd60);
        fev[3] = mk(1'b1, 8'h44, 7'd70, 7'd80);
        fev[4] = mk(1'b0, 8'h55, 7'd90, 7'd99);

        drive(0, tbl[0], 1'b0);
        drive(1, tbl[0], 1'b0);

        reset = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_ready", int'(if0.ev_ready), 0);
        chk("rst_sclk", int'(sclk[0]), 0);
        chk("rst_mosi", int'(mosi[0]), 0);
        chk("rst_cs_n", int'(cs_n[0]), 1);
        chk("rst_busy", int'(busy[0]), 0);
        chk("rst_count", int'(cnt0), 0);
        chk("rst_msg", int'(msg[0]), 0);
        reset = 1'b0;
        #1;
        chk("post_rst_ready", int'(if0.ev_ready), 1);
        @(negedge clk);

        for (int i = 0; i < 5; i++)
            run_vec(0, tbl[i], 81, $sformatf("tbl%0d", i));

        // Hold valid with five events; the FSM pops the first one early.
        m = msg_cnt[0];
        k = 0;
        t = 0;
        while (k < 5 && t < 1000) begin
            drive(0, fev[k], 1'b1);
            if (rdy(0)) begin
                push_exp(0, fev[k]);
                k++;
            end
            @(negedge clk);
            t++;
        end
        drive(0, fev[0], 1'b0);
        chk("full_accepted", k, 5);
        chk("full_count", int'(cnt0), 4);
        chk("full_ready", int'(if0.ev_ready), 0);
        chk("full_busy", int'(busy[0]), 1);
        wait_msgs(0, m + 5, 5 * 400);
        repeat (2) @(negedge clk);
        for (int j = 1; j < 5; j++) begin
            act = (mc0.size() > m + j) ? mc0[m + j] - mc0[m + j - 1] : -1;
            chk($sformatf("b2b_interval%0d", j), act, 1 + int'(fev[j].nb) * 81);
        end
        drain(0, "fifo_full");

        // Abort during bit 4 of byte 1 (12th SCLK rise of the message).
        m = msg_cnt[0];
        r = rises[0];
        send(0, tbl[0], acc);
        t = 0;
        while (rises[0] - r < 12 && t < 500) begin
            @(negedge clk);
            t++;
        end
        chk("abort_reached", rises[0] - r, 12);
        reset = 1'b1;
        @(negedge clk);
        chk("abort_sclk", int'(sclk[0]), 0);
        chk("abort_cs_n", int'(cs_n[0]), 1);
        chk("abort_count", int'(cnt0), 0);
        chk("abort_busy", int'(busy[0]), 0);
        reset = 1'b0;
        repeat (400) @(negedge clk);
        chk("abort_no_msg", msg_cnt[0] - m, 0);
        chk("abort_rx_bytes", rx0.size() - rd0, 1);
        act = (rx0.size() > rd0) ? int'(rx0[rd0]) : -1;
        chk("abort_byte0", act, 8'h90);
        rd0 = rx0.size();
        exq0.delete();
        run_vec(0, tbl[1], 81, "post_abort");
        run_vec(0, tbl[0], 81, "post_abort_on");

        run_vec(1, tbl[0], 18, "fast_on");
        run_vec(1, tbl[1], 18, "fast_off");

        m = msg_cnt[1];
        for (int i = 0; i < 10; i++) begin
            v = mk(1'($urandom_range(0, 1)), 8'($urandom), 7'($urandom), 7'($urandom));
            send(1, v, acc);
        end
        wait_msgs(1, m + 10, 10 * 120);
        repeat (3) @(negedge clk);
        drain(1, "random");

        chk("fast_high_width", hi_max[1], 1);
        chk("slow_high_width", hi_max[0], 4);
        chk("slow_mosi_stable", glitch[0], 0);
        chk("fast_mosi_stable", glitch[1], 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
